seven_seg_rx: RTL and testbench
===============================

// Module: seven_seg_rx
// PURPOSE
//  Receiver/decoder for the multiplexed two-digit 7-segment Pmod bus our display controller drives.
//  Samples the 8-bit bus, filters glitches and demultiplexes MSB/LSB digits by the select bit.
//  Maps segment patterns back to nibbles and emits one 8-bit value per completed digit pair.
//  Used for loopback self-test and for board-to-board readout of the stopwatch display.
// PARAMETERS
//  SYNC_STAGES     2     input synchroniser depth (flops on seg_in before any logic), >=2
//  STABLE_CYCLES   8     consecutive identical synced samples required to accept a bus value, >=2
//  TIMEOUT_CYCLES  4096  cycles without an accepted sample before link_lost asserts
// PORTS
//  CLK         in   1  single clock; all logic on posedge CLK
//  RST         in   1  synchronous, active-high reset
//  seg_in      in   8  [6:0] active-low segments a..g (bit0=a), [7] digit select: 1=LSB, 0=MSB
//  dout        out  8  decoded value {msb_nibble, lsb_nibble}; holds between frames
//  dout_valid  out  1  one-cycle pulse: dout/dout_err updated this cycle
//  dout_err    out  1  qualifies dout_valid: 1 if either digit of the frame was an illegal pattern
//  link_lost   out  1  1 = no accepted sample within TIMEOUT_CYCLES (or since reset)
// BEHAVIOUR
//  Reset (RST=1 at a posedge): dout=0, dout_valid=0, dout_err=0, link_lost=1.
//   Also clears the synchroniser, stable counter, last-accepted register, digit regs and timeout counter. FSM goes to IDLE.
//  Filter: s = synchroniser output. stable_cnt clears when s != s_prev, else increments, saturating at STABLE_CYCLES.
//   Exactly one accept pulse per stable period, in the cycle stable_cnt reaches STABLE_CYCLES.
//   A value held shorter than STABLE_CYCLES produces no accept.
//   A value held indefinitely produces one accept only.
//  Decode on accept: seg = ~s[6:0]. Legal map, hex seg->nibble:
//   3F->0 06->1 5B->2 4F->3 66->4 6D->5 7D->6 07->7 7F->8 6F->9 77->A 7C->B 39->C 5E->D 79->E 71->F.
//   Any other pattern (incl. 00 blank, 40 dash) -> nibble 0, digit error flag set.
//  FSM, evaluated only on accept (no change otherwise):
//   IDLE    : sel=1 -> store LSB, go GOT_LSB; sel=0 -> store MSB, go GOT_MSB
//   GOT_LSB : sel=1 -> overwrite LSB, stay; sel=0 -> store MSB, emit frame, go IDLE
//   GOT_MSB : sel=0 -> overwrite MSB, stay; sel=1 -> store LSB, emit frame, go IDLE
//   Emit frame: dout, dout_err registered, dout_valid=1 for one cycle.
//   dout_err = OR of the two stored digit error flags.
//  Latency: dout_valid is high exactly SYNC_STAGES+STABLE_CYCLES+1 cycles after the posedge at which seg_in first shows the completing digit.
//  Timeout: counter clears on every accept, otherwise increments, saturating.
//   Reaching TIMEOUT_CYCLES sets link_lost=1 and forces the FSM to IDLE, discarding any half frame.
//   link_lost clears on the next accept.
//  Simultaneous accept and timeout expiry in one cycle: the accept wins. Counter clears, link_lost=0, FSM processes the digit.
//  Reset mid-frame: the half frame is discarded; a following lone digit does not emit.
//  Width rules: counters sized $clog2(param+1); no wrap, all counters saturate.
// TESTING
//  1 Assert RST 3 cycles, release -> dout=00, dout_valid=0, dout_err=0, link_lost=1.
//  2 seg_in={1,~5B} for 20 cycles, then {0,~4F} held -> single dout_valid, dout=32, dout_err=0.
//    The pulse lands exactly SYNC_STAGES+STABLE_CYCLES+1 cycles after the MSB edge; link_lost=0 after the first accept.
//  3 After LSB 2 is accepted, {0,~4F} for STABLE_CYCLES-1 cycles, then back to {1,~5B} -> no accept, no dout_valid.
//  4 LSB {1,~6D}, then MSB {0,~40} -> dout_valid, dout=05, dout_err=1.
//    The next clean pair LSB 9 / MSB 1 -> dout=19, dout_err=0.
//  5 LSB 1, then LSB 7 (each held 20 cycles), then MSB 4 -> exactly one frame, dout=47.
//    Also MSB-first order: MSB 8 then LSB 0 -> dout=80.
//  6 Hold the bus constant after the last accept -> link_lost=1 exactly TIMEOUT_CYCLES cycles later.
//    An LSB accepted, then RST, then MSB only -> no dout_valid.

Source files
------------

// File: rtl/seven_seg_rx.sv
// seven_seg_rx: receiver for the multiplexed two-digit 7-segment display bus.
// Synchronises and glitch-filters seg_in, decodes every accepted digit and
// pairs MSB/LSB digits into one byte per completed frame. A watchdog flags a
// silent link and drops any half-received frame.
module seven_seg_rx #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned STABLE_CYCLES  = 8,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] seg_in,
    output logic [7:0] dout,
    output logic       dout_valid,
    output logic       dout_err,
    output logic       link_lost
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [TO_W-1:0]  TO_MAX     = TO_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GOT_LSB = 2'd1,
        GOT_MSB = 2'd2
    } state_t;

    // Active-high segment pattern -> {error, nibble}; unknown patterns give nibble 0.
    function automatic logic [4:0] decode_seg(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'h3F:   r = 5'h00;
            7'h06:   r = 5'h01;
            7'h5B:   r = 5'h02;
            7'h4F:   r = 5'h03;
            7'h66:   r = 5'h04;
            7'h6D:   r = 5'h05;
            7'h7D:   r = 5'h06;
            7'h07:   r = 5'h07;
            7'h7F:   r = 5'h08;
            7'h6F:   r = 5'h09;
            7'h77:   r = 5'h0A;
            7'h7C:   r = 5'h0B;
            7'h39:   r = 5'h0C;
            7'h5E:   r = 5'h0D;
            7'h79:   r = 5'h0E;
            7'h71:   r = 5'h0F;
            default: r = 5'h10;
        endcase
        return r;
    endfunction

    logic [SYNC_STAGES-1:0][7:0] sync_q, sync_d;
    logic [7:0]       s;
    logic [7:0]       s_prev_q, s_prev_d;
    logic [CNT_W-1:0] stable_cnt_q, stable_cnt_d;
    logic             accept_q, accept_d;
    logic [7:0]       acc_val_q, acc_val_d;
    state_t           state_q, state_d;
    logic [3:0]       lsb_q, lsb_d;
    logic             lsb_err_q, lsb_err_d;
    logic [3:0]       msb_q, msb_d;
    logic             msb_err_q, msb_err_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             link_lost_q, link_lost_d;
    logic [7:0]       dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             dout_err_q, dout_err_d;
    logic [4:0]       dec;

    assign s = sync_q[SYNC_STAGES-1];

    // Synchroniser shift and stability filter: one accept per stable period.
    always_comb begin
        sync_d       = {sync_q[SYNC_STAGES-2:0], seg_in};
        s_prev_d     = s;
        stable_cnt_d = stable_cnt_q;
        if (s != s_prev_q) begin
            stable_cnt_d = '0;
        end else if (stable_cnt_q != STABLE_MAX) begin
            stable_cnt_d = stable_cnt_q + CNT_W'(1);
        end
        accept_d  = (stable_cnt_d == STABLE_MAX) && (stable_cnt_q != STABLE_MAX);
        acc_val_d = accept_d ? s : acc_val_q;
    end

    // Digit pairing FSM and link watchdog; an accept beats a coincident timeout.
    always_comb begin
        state_d      = state_q;
        lsb_d        = lsb_q;
        lsb_err_d    = lsb_err_q;
        msb_d        = msb_q;
        msb_err_d    = msb_err_q;
        to_cnt_d     = to_cnt_q;
        link_lost_d  = link_lost_q;
        dout_d       = dout_q;
        dout_err_d   = dout_err_q;
        dout_valid_d = 1'b0;
        dec          = decode_seg(~acc_val_q[6:0]);

        if (accept_q) begin
            to_cnt_d    = '0;
            link_lost_d = 1'b0;
            if (acc_val_q[7]) begin
                lsb_d     = dec[3:0];
                lsb_err_d = dec[4];
                if (state_q == GOT_MSB) begin
                    dout_d       = {msb_q, dec[3:0]};
                    dout_err_d   = msb_err_q | dec[4];
                    dout_valid_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    state_d = GOT_LSB;
                end
            end else begin
                msb_d     = dec[3:0];
                msb_err_d = dec[4];
                if (state_q == GOT_LSB) begin
                    dout_d       = {dec[3:0], lsb_q};
                    dout_err_d   = lsb_err_q | dec[4];
                    dout_valid_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    state_d = GOT_MSB;
                end
            end
        end else begin
            if (to_cnt_q != TO_MAX) begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
            if (to_cnt_d == TO_MAX) begin
                link_lost_d = 1'b1;
                state_d     = IDLE;
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q       <= '0;
            s_prev_q     <= '0;
            stable_cnt_q <= '0;
            accept_q     <= 1'b0;
            acc_val_q    <= '0;
            state_q      <= IDLE;
            lsb_q        <= '0;
            lsb_err_q    <= 1'b0;
            msb_q        <= '0;
            msb_err_q    <= 1'b0;
            to_cnt_q     <= '0;
            link_lost_q  <= 1'b1;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            dout_err_q   <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            s_prev_q     <= s_prev_d;
            stable_cnt_q <= stable_cnt_d;
            accept_q     <= accept_d;
            acc_val_q    <= acc_val_d;
            state_q      <= state_d;
            lsb_q        <= lsb_d;
            lsb_err_q    <= lsb_err_d;
            msb_q        <= msb_d;
            msb_err_q    <= msb_err_d;
            to_cnt_q     <= to_cnt_d;
            link_lost_q  <= link_lost_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            dout_err_q   <= dout_err_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign dout_err   = dout_err_q;
    assign link_lost  = link_lost_q;

endmodule

// File: tb/tb_seven_seg_rx.sv
// tb_seven_seg_rx: table-driven digit pairs, hand sequences for latency,
// glitch, timeout and reset corners, then random bus traffic, all checked
// cycle by cycle against a run-length based reference model.
`timescale 1ns/1ps
module tb_seven_seg_rx;

    localparam int SYNC    = 2;
    localparam int STABLE  = 8;
    localparam int TIMEOUT = 4096;
    localparam int LAT     = SYNC + STABLE + 1;
    localparam logic [6:0] LEGAL [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] seg_in;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_err;
    logic       link_lost;

    seven_seg_rx #(
        .SYNC_STAGES   (SYNC),
        .STABLE_CYCLES (STABLE),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .seg_in    (seg_in),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_err  (dout_err),
        .link_lost (link_lost)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // reference model state
    logic [7:0] run_val;
    int         run_start;
    bit         run_acc;
    int         pend_t[$];
    logic [7:0] pend_v[$];
    int         m_state;          // 0 none, 1 holding LSB, 2 holding MSB
    logic [3:0] m_lsb, m_msb;
    logic       m_lerr, m_merr;
    bit         have_prev;
    int         last_proc;
    logic [7:0] m_dout;
    logic       m_err, m_valid, m_ll;

    // observed events
    int         valid_cnt = 0;
    int         last_valid_cyc = -1;
    int         ll_rise_cyc = -1;
    logic [7:0] last_dout;
    logic       last_err;
    logic       ll_prev = 1'b1;

    typedef struct {
        int         n;
        logic [7:0] d0, d1, d2;
        logic [7:0] exp_dout;
        logic       exp_err;
    } vec_t;
    vec_t vecs[7];

    function automatic logic [7:0] bus(input logic sel, input logic [6:0] pat);
        return {sel, ~pat};
    endfunction

    function automatic logic [4:0] ref_decode(input logic [6:0] pat);
        for (int i = 0; i < 16; i++) begin
            if (LEGAL[i] == pat) return {1'b0, 4'(i)};
        end
        return 5'h10;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // A bus value is accepted once it has been sampled STABLE+1 times in a row;
    // its digit takes effect SYNC+STABLE+1 cycles after its first sample.
    task automatic model_update(input logic [7:0] b, input logic rst);
        logic [7:0] v;
        logic [4:0] d;
        m_valid = 1'b0;
        if (rst) begin
            run_val   = 8'h00;
            run_start = cyc - SYNC;
            run_acc   = 1'b0;
            pend_t.delete();
            pend_v.delete();
            m_state   = 0;
            have_prev = 1'b0;
            m_dout    = 8'h00;
            m_err     = 1'b0;
            m_ll      = 1'b1;
            return;
        end
        if (b != run_val) begin
            run_val   = b;
            run_start = cyc;
            run_acc   = 1'b0;
        end
        if (!run_acc && (cyc - run_start == STABLE)) begin
            pend_t.push_back(run_start + LAT);
            pend_v.push_back(b);
            run_acc = 1'b1;
        end
        while (pend_t.size() > 0 && pend_t[0] == cyc) begin
            void'(pend_t.pop_front());
            v = pend_v.pop_front();
            if (have_prev && (cyc - last_proc > TIMEOUT)) m_state = 0;
            have_prev = 1'b1;
            last_proc = cyc;
            d = ref_decode(~v[6:0]);
            if (v[7]) begin
                m_lsb = d[3:0]; m_lerr = d[4];
                if (m_state == 2) begin
                    m_dout = {m_msb, m_lsb}; m_err = m_lerr | m_merr; m_valid = 1'b1; m_state = 0;
                end else m_state = 1;
            end else begin
                m_msb = d[3:0]; m_merr = d[4];
                if (m_state == 1) begin
                    m_dout = {m_msb, m_lsb}; m_err = m_lerr | m_merr; m_valid = 1'b1; m_state = 0;
                end else m_state = 2;
            end
        end
        m_ll = !have_prev || (cyc - last_proc >= TIMEOUT);
    endtask

    task automatic step();
        @(posedge CLK);
        cyc++;
        model_update(seg_in, RST);
        #1;
        chk("dout_valid", 8'(dout_valid), 8'(m_valid));
        chk("dout", dout, m_dout);
        chk("dout_err", 8'(dout_err), 8'(m_err));
        chk("link_lost", 8'(link_lost), 8'(m_ll));
        if (dout_valid) begin
            valid_cnt++;
            last_valid_cyc = cyc;
            last_dout = dout;
            last_err = dout_err;
        end
        if (link_lost && !ll_prev) ll_rise_cyc = cyc;
        ll_prev = link_lost;
    endtask

    task automatic drive(input logic [7:0] v, input int n);
        seg_in = v;
        repeat (n) step();
    endtask

    task automatic set_vec(input int i, input int n, input logic [7:0] d0, input logic [7:0] d1,
                           input logic [7:0] d2, input logic [7:0] e, input logic ee);
        vecs[i].n = n; vecs[i].d0 = d0; vecs[i].d1 = d1; vecs[i].d2 = d2;
        vecs[i].exp_dout = e; vecs[i].exp_err = ee;
    endtask

    initial begin
        int v0, c, p, target, hold;
        logic [7:0] ds[3];
        logic [6:0] pat;

        set_vec(0, 2, bus(1, 7'h6D), bus(0, 7'h40), 8'h00, 8'h05, 1'b1);
        set_vec(1, 2, bus(1, 7'h6F), bus(0, 7'h06), 8'h00, 8'h19, 1'b0);
        set_vec(2, 3, bus(1, 7'h06), bus(1, 7'h07), bus(0, 7'h66), 8'h47, 1'b0);
        set_vec(3, 2, bus(0, 7'h7F), bus(1, 7'h3F), 8'h00, 8'h80, 1'b0);
        set_vec(4, 2, bus(0, 7'h71), bus(1, 7'h77), 8'h00, 8'hFA, 1'b0);
        set_vec(5, 2, bus(1, 7'h00), bus(0, 7'h39), 8'h00, 8'hC0, 1'b1);
        set_vec(6, 3, bus(0, 7'h7C), bus(0, 7'h5E), bus(1, 7'h79), 8'hDE, 1'b0);

        // reset
        RST = 1'b1;
        seg_in = 8'hFF;
        repeat (3) step();
        RST = 1'b0;
        step();
        chk("reset dout", dout, 8'h00);
        chk("reset dout_valid", 8'(dout_valid), 8'h00);
        chk("reset dout_err", 8'(dout_err), 8'h00);
        chk("reset link_lost", 8'(link_lost), 8'h01);

        // basic pair with latency
        drive(bus(1, 7'h5B), 20);
        chk("link_lost after accept", 8'(link_lost), 8'h00);
        c = cyc;
        v0 = valid_cnt;
        drive(bus(0, 7'h4F), 40);
        chk_int("pair frame count", valid_cnt - v0, 1);
        chk_int("pair latency cycle", last_valid_cyc, c + 1 + LAT);
        chk("pair dout", last_dout, 8'h32);
        chk("pair dout_err", 8'(last_err), 8'h00);

        // short glitch is ignored
        v0 = valid_cnt;
        drive(bus(1, 7'h5B), 20);
        drive(bus(0, 7'h4F), STABLE - 1);
        drive(bus(1, 7'h5B), 20);
        chk_int("glitch frame count", valid_cnt - v0, 0);

        // table of digit sequences
        for (int i = 0; i < 7; i++) begin
            ds[0] = vecs[i].d0; ds[1] = vecs[i].d1; ds[2] = vecs[i].d2;
            v0 = valid_cnt;
            for (int k = 0; k < vecs[i].n; k++) drive(ds[k], 20);
            chk_int("vec frame count", valid_cnt - v0, 1);
            chk("vec dout", last_dout, vecs[i].exp_dout);
            chk("vec dout_err", 8'(last_err), 8'(vecs[i].exp_err));
        end

        // timeout after the bus goes quiet
        p = last_valid_cyc;
        ll_rise_cyc = -1;
        repeat (TIMEOUT + 10) step();
        chk_int("timeout rise cycle", ll_rise_cyc, p + TIMEOUT);

        // second digit lands exactly on timeout expiry: accept wins
        c = cyc;
        seg_in = bus(1, 7'h66);
        ll_rise_cyc = -1;
        p = c + 1 + LAT;
        target = p + TIMEOUT - LAT - 1;
        while (cyc < target) step();
        v0 = valid_cnt;
        drive(bus(0, 7'h7D), 20);
        chk_int("tie frame count", valid_cnt - v0, 1);
        chk("tie dout", last_dout, 8'h64);
        chk_int("tie no link loss", ll_rise_cyc, -1);

        // one cycle later: half frame discarded
        c = cyc;
        seg_in = bus(1, 7'h07);
        ll_rise_cyc = -1;
        p = c + 1 + LAT;
        target = p + TIMEOUT - LAT;
        while (cyc < target) step();
        v0 = valid_cnt;
        drive(bus(0, 7'h7D), 20);
        chk_int("expired frame count", valid_cnt - v0, 0);
        chk_int("expired rise cycle", ll_rise_cyc, p + TIMEOUT);
        drive(bus(1, 7'h06), 20);
        chk_int("after expiry frame count", valid_cnt - v0, 1);
        chk("after expiry dout", last_dout, 8'h61);
        chk("after expiry link_lost", 8'(link_lost), 8'h00);

        // reset mid-frame
        drive(bus(1, 7'h4F), 20);
        RST = 1'b1;
        seg_in = bus(0, 7'h6D);
        repeat (2) step();
        RST = 1'b0;
        v0 = valid_cnt;
        repeat (30) step();
        chk_int("reset mid-frame count", valid_cnt - v0, 0);
        drive(bus(1, 7'h5B), 20);
        chk_int("post reset frame count", valid_cnt - v0, 1);
        chk("post reset dout", last_dout, 8'h52);

        // random traffic against the model
        for (int it = 0; it < 250; it++) begin
            if ($urandom_range(0, 39) == 0) begin
                RST = 1'b1;
                seg_in = 8'($urandom);
                repeat ($urandom_range(1, 3)) step();
                RST = 1'b0;
            end else begin
                if ($urandom_range(0, 3) != 0) pat = LEGAL[$urandom_range(0, 15)];
                else pat = 7'($urandom);
                if ($urandom_range(0, 79) == 0) hold = int'($urandom_range(TIMEOUT - 4, TIMEOUT + 4));
                else hold = int'($urandom_range(1, 25));
                drive(bus(1'($urandom), pat), hold);
            end
        end
        drive(8'hFF, 20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
